addsub_arbiter: RTL and testbench

ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

---
 rtl/addsub_arbiter_pkg.sv | 19 +
 rtl/addsub_core.sv | 29 ++
 rtl/addsub_arbiter.sv | 153 +++++++++++++++
 tb/tb_addsub_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_arbiter_pkg.sv
// Shared types and constants for the two-requester add/subtract unit.
// Optional build macro: ADDSUB_ARB_RR_EN selects round-robin arbitration.
package addsub_arbiter_pkg;

    // Controller states: IDLE accepts, EXEC computes, RESP presents the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Operation encoding carried on reqN_sub.
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Default operand/result width.
    localparam int DEFAULT_WIDTH = 32;

endpackage

// File: rtl/addsub_core.sv
// Purely combinational adder/subtractor with carry and signed-overflow flags.
// Subtraction is a + ~b + 1, so carry = 1 means "no borrow".
module addsub_core
    import addsub_arbiter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             ovf
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   ext;

    // One WIDTH+1 bit addition covers both operations; overflow compares the
    // sign of the effective operands with the sign of the result.
    always_comb begin
        b_eff = (sub == OP_SUB) ? ~b : b;
        ext   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
        sum   = ext[WIDTH-1:0];
        carry = ext[WIDTH];
        ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (ext[WIDTH-1] != a[WIDTH-1]);
    end

endmodule

// File: rtl/addsub_arbiter.sv
// Two requesters share one add/subtract core through a 3-state controller.
// Optional build macro: ADDSUB_ARB_RR_EN -> round-robin between requesters;
// undefined -> fixed priority with requester 0 winning ties.
//
// Handshakes: a request transfers on a cycle where reqN_valid && reqN_ready;
// ready is only ever raised in IDLE, for at most one requester, and the
// requester holds its operands while valid is high and ready is low. A
// response transfers on a cycle where rsp_valid && rsp_ready; rsp_* stay
// stable while rsp_valid is high and rsp_ready is low.
module addsub_arbiter
    import addsub_arbiter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req0_sub,
    input  logic             req1_sub,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_carry,
    output logic             rsp_ovf,
    output logic             busy,
    output state_t           dbg_state
);

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_sub;
    logic             op_id;
    logic             grant0;
    logic             grant1;
    logic [WIDTH-1:0] core_sum;
    logic             core_carry;
    logic             core_ovf;

    assign dbg_state = state;

`ifdef ADDSUB_ARB_RR_EN
    // Requester granted most recently; resets to 1 so requester 0 wins the first tie.
    logic last_grant;

    // Remember who was served so the other side wins the next tie.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_grant <= 1'b1;
        end else if (grant0 || grant1) begin
            last_grant <= grant1;
        end
    end

    // Round-robin grant: a lone valid always wins, a tie goes to the side not served last.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE && !RST) begin
            if (req0_valid && req1_valid) begin
                grant0 = last_grant;
                grant1 = !last_grant;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end
`else
    // Fixed-priority grant: requester 0 wins whenever it is valid.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE && !RST) begin
            grant0 = req0_valid;
            grant1 = req1_valid && !req0_valid;
        end
    end
`endif

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    addsub_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .a    (op_a),
        .b    (op_b),
        .sub  (op_sub),
        .sum  (core_sum),
        .carry(core_carry),
        .ovf  (core_ovf)
    );

    // Controller: latch the granted operation, register the result, hold it until taken.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            op_a      <= '0;
            op_b      <= '0;
            op_sub    <= 1'b0;
            op_id     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_sum   <= '0;
            rsp_carry <= 1'b0;
            rsp_ovf   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        op_a   <= grant1 ? req1_a : req0_a;
                        op_b   <= grant1 ? req1_b : req0_b;
                        op_sub <= grant1 ? req1_sub : req0_sub;
                        op_id  <= grant1;
                        busy   <= 1'b1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_sum   <= core_sum;
                    rsp_carry <= core_carry;
                    rsp_ovf   <= core_ovf;
                    rsp_id    <= op_id;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Self-checking bench for addsub_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level model (result arithmetic + expected-response queue).
module tb_addsub_arbiter;
    import addsub_arbiter_pkg::*;

    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         v0 = 1'b0, v1 = 1'b0;
    logic         s0 = 1'b0, s1 = 1'b0;
    logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic         rsp_ready = 1'b1;

    logic         req0_ready, req1_ready;
    logic         rsp_valid, rsp_id, rsp_carry, rsp_ovf, busy;
    logic [W-1:0] rsp_sum;
    state_t       dbg_state;

    addsub_arbiter #(.WIDTH(W)) dut (
        .CLK(CLK), .RST(RST),
        .req0_valid(v0), .req1_valid(v1),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a(a0), .req0_b(b0), .req1_a(a1), .req1_b(b1),
        .req0_sub(s0), .req1_sub(s1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_sum(rsp_sum),
        .rsp_carry(rsp_carry), .rsp_ovf(rsp_ovf),
        .busy(busy), .dbg_state(dbg_state)
    );

    // Clock
    always #5 CLK = ~CLK;

    // Scoreboard and model state
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [34:0] exp_q[$];      // {id, carry, ovf, sum}
    int          m_age = -1;    // -1: no op in flight; 0: accepted last edge; >=1: response due
    logic        m_last = 1'b1; // requester granted most recently

    // Observations from the latest step
    logic         s_gnt0, s_gnt1, s_valid, s_hs;
    int           s_cyc;
    logic         got_id, got_carry, got_ovf;
    logic [W-1:0] got_sum;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Result from plain integer arithmetic: {carry, ovf, sum}
    function automatic logic [33:0] ref_calc(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        longint sa, sb, sr;
        logic [32:0] u;
        logic carry, ovf;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!sub) begin
            u = {1'b0, a} + {1'b0, b};
            carry = u[32];
            sr = sa + sb;
        end else begin
            u = {1'b0, a} - {1'b0, b};
            carry = (a >= b);
            sr = sa - sb;
        end
        ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        return {carry, ovf, u[31:0]};
    endfunction

    function automatic logic [W-1:0] rand_opnd();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // One cycle: called just after a negedge with inputs already driven.
    // Checks outputs against the model, then advances the model at the edge.
    task automatic step();
        logic g0, g1;
        logic [34:0] e;
        #1;
        g0 = 1'b0;
        g1 = 1'b0;
        if (m_age < 0) begin
            if (v0 && v1) begin
`ifdef ADDSUB_ARB_RR_EN
                if (m_last) g0 = 1'b1; else g1 = 1'b1;
`else
                g0 = 1'b1;
`endif
            end else if (v0) g0 = 1'b1;
            else if (v1) g1 = 1'b1;
        end
        chk("req0_ready", 64'(req0_ready), 64'(g0));
        chk("req1_ready", 64'(req1_ready), 64'(g1));
        chk("busy", 64'(busy), 64'(m_age >= 0));
        chk("rsp_valid", 64'(rsp_valid), 64'(m_age >= 1));
        if (m_age >= 1) begin
            if (exp_q.size() == 0) begin
                chk("exp_q_empty", 64'(0), 64'(1));
            end else begin
                e = exp_q[0];
                chk("rsp_id", 64'(rsp_id), 64'(e[34]));
                chk("rsp_carry", 64'(rsp_carry), 64'(e[33]));
                chk("rsp_ovf", 64'(rsp_ovf), 64'(e[32]));
                chk("rsp_sum", 64'(rsp_sum), 64'(e[31:0]));
            end
        end
        s_gnt0 = req0_ready;
        s_gnt1 = req1_ready;
        s_valid = rsp_valid;
        s_hs = rsp_valid && rsp_ready;
        s_cyc = cyc;
        if (rsp_valid) begin
            got_id = rsp_id;
            got_sum = rsp_sum;
            got_carry = rsp_carry;
            got_ovf = rsp_ovf;
        end
        @(posedge CLK);
        cyc++;
        if (m_age < 0) begin
            if (g0) begin
                exp_q.push_back({1'b0, ref_calc(a0, b0, s0)});
                m_last = 1'b0;
                m_age = 0;
            end else if (g1) begin
                exp_q.push_back({1'b1, ref_calc(a1, b1, s1)});
                m_last = 1'b1;
                m_age = 0;
            end
        end else if (m_age == 0) begin
            m_age = 1;
        end else if (rsp_ready) begin
            m_age = -1;
            void'(exp_q.pop_front());
        end
        @(negedge CLK);
    endtask

    task automatic model_reset();
        m_age = -1;
        m_last = 1'b1;
        exp_q.delete();
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req0_ready", 64'(req0_ready), 64'(0));
        chk("rst_req1_ready", 64'(req1_ready), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_id", 64'(rsp_id), 64'(0));
        chk("rst_rsp_sum", 64'(rsp_sum), 64'(0));
        chk("rst_rsp_carry", 64'(rsp_carry), 64'(0));
        chk("rst_rsp_ovf", 64'(rsp_ovf), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_state", 64'(dbg_state), 64'(IDLE));
    endtask

    // Issue one operation from requester id and run it to its response.
    // hold = cycles rsp_ready stays low once the response is up; other = also
    // raise the other requester while this op is in flight.
    task automatic do_op(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub, input int hold, input logic other);
        int gnt_c, val_c, held;
        logic done;
        if (id) begin v1 = 1'b1; a1 = a; b1 = b; s1 = sub; end
        else    begin v0 = 1'b1; a0 = a; b0 = b; s0 = sub; end
        rsp_ready = (hold == 0);
        gnt_c = -1; val_c = -1; held = 0; done = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            step();
            if (id ? s_gnt1 : s_gnt0) begin
                if (id) v1 = 1'b0; else v0 = 1'b0;
                gnt_c = s_cyc;
                if (other) begin
                    if (id) begin v0 = 1'b1; a0 = 32'd100; b0 = 32'd1; s0 = OP_ADD; end
                    else    begin v1 = 1'b1; a1 = 32'd100; b1 = 32'd1; s1 = OP_ADD; end
                end
            end
            if (s_valid && val_c < 0) val_c = s_cyc;
            if (s_valid && held < hold) begin
                held++;
                chk("hold_busy", 64'(busy), 64'(1));
                chk("hold_no_ready", 64'({req0_ready, req1_ready}), 64'(0));
                if (held == hold) rsp_ready = 1'b1;
            end
            if (s_hs) done = 1'b1;
        end
        if (!done) chk("op_timeout", 64'(0), 64'(1));
        chk("latency", 64'(val_c - gnt_c), 64'(2));
    endtask

    task automatic drain(input int n);
        v0 = 1'b0;
        v1 = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < n; i++) step();
    endtask

    // Main sequence
    initial begin
        int gq[$];
        int exp_order[4];

        // Reset with a valid asserted: nothing may be granted.
        v0 = 1'b1; a0 = 32'd9; b0 = 32'd9;
        repeat (2) @(negedge CLK);
        #1;
        chk_reset_outputs();
        v0 = 1'b0;
        RST = 1'b0;
        model_reset();
        @(negedge CLK);

        // 5 + 3
        do_op(1'b0, 32'd5, 32'd3, OP_ADD, 0, 1'b0);
        chk("add_id", 64'(got_id), 64'(0));
        chk("add_sum", 64'(got_sum), 64'd8);
        chk("add_carry", 64'(got_carry), 64'(0));
        chk("add_ovf", 64'(got_ovf), 64'(0));

        // 3 - 5 borrows, 5 - 3 does not
        do_op(1'b1, 32'd3, 32'd5, OP_SUB, 0, 1'b0);
        chk("sub_neg_id", 64'(got_id), 64'(1));
        chk("sub_neg_sum", 64'(got_sum), 64'hFFFF_FFFE);
        chk("sub_neg_carry", 64'(got_carry), 64'(0));
        chk("sub_neg_ovf", 64'(got_ovf), 64'(0));
        do_op(1'b1, 32'd5, 32'd3, OP_SUB, 0, 1'b0);
        chk("sub_pos_sum", 64'(got_sum), 64'd2);
        chk("sub_pos_carry", 64'(got_carry), 64'(1));

        // Signed overflow and unsigned wrap
        do_op(1'b0, 32'h7FFF_FFFF, 32'd1, OP_ADD, 0, 1'b0);
        chk("ovf_sum", 64'(got_sum), 64'h8000_0000);
        chk("ovf_ovf", 64'(got_ovf), 64'(1));
        chk("ovf_carry", 64'(got_carry), 64'(0));
        do_op(1'b0, 32'hFFFF_FFFF, 32'd1, OP_ADD, 0, 1'b0);
        chk("wrap_sum", 64'(got_sum), 64'd0);
        chk("wrap_carry", 64'(got_carry), 64'(1));
        chk("wrap_ovf", 64'(got_ovf), 64'(0));

        // Backpressure for 5 cycles with the other requester waiting
        do_op(1'b0, 32'd20, 32'd22, OP_ADD, 5, 1'b1);
        chk("hold_sum", 64'(got_sum), 64'd42);
        drain(8);
        chk("post_hold_idle", 64'(busy), 64'(0));

        // Reset during EXEC discards the operation
        v0 = 1'b1; a0 = 32'd1; b0 = 32'd2; s0 = OP_ADD;
        rsp_ready = 1'b1;
        step();
        chk("exec_grant", 64'(s_gnt0), 64'(1));
        v0 = 1'b0;
        RST = 1'b1;
        #1;
        chk_reset_outputs();
        model_reset();
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 3; i++) step();

        // Both valid continuously for 4 grants
        v0 = 1'b1; a0 = 32'd10; b0 = 32'd1; s0 = OP_ADD;
        v1 = 1'b1; a1 = 32'd10; b1 = 32'd1; s1 = OP_SUB;
        rsp_ready = 1'b1;
        for (int n = 0; n < 60 && gq.size() < 4; n++) begin
            step();
            if (s_gnt0) gq.push_back(0);
            if (s_gnt1) gq.push_back(1);
        end
        drain(6);
`ifdef ADDSUB_ARB_RR_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0};
`endif
        chk("order_count", 64'(gq.size()), 64'(4));
        for (int i = 0; i < 4 && i < gq.size(); i++)
            chk($sformatf("order_%0d", i), 64'(gq[i]), 64'(exp_order[i]));

        // Next request after the reset is served normally
        do_op(1'b1, 32'd7, 32'd7, OP_ADD, 0, 1'b0);
        chk("after_rst_sum", 64'(got_sum), 64'd14);
        chk("after_rst_id", 64'(got_id), 64'(1));

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
            if (s_gnt0) v0 = 1'b0;
            else if (v0 && $urandom_range(0, 15) == 0) v0 = 1'b0;
            else if (!v0 && $urandom_range(0, 1) == 1) begin
                v0 = 1'b1; a0 = rand_opnd(); b0 = rand_opnd(); s0 = 1'($urandom_range(0, 1));
            end
            if (s_gnt1) v1 = 1'b0;
            else if (v1 && $urandom_range(0, 15) == 0) v1 = 1'b0;
            else if (!v1 && $urandom_range(0, 1) == 1) begin
                v1 = 1'b1; a1 = rand_opnd(); b1 = rand_opnd(); s1 = 1'($urandom_range(0, 1));
            end
        end
        drain(8);
        chk("final_queue_empty", 64'(exp_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
